// File: rtl/sensor_i2c_slave_pkg.sv
// ---------------------------------------------------------------------------
// sensor_i2c_slave_pkg
//   Shared definitions for the sensor I2C responder: FSM state encoding,
//   ACK/NACK bus levels, write-word byte phase and the default device address.
// ---------------------------------------------------------------------------
package sensor_i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEVA      = 4'd1,
        ST_DEVA_ACK  = 4'd2,
        ST_REGA      = 4'd3,
        ST_REGA_ACK  = 4'd4,
        ST_WDAT      = 4'd5,
        ST_WDAT_ACK  = 4'd6,
        ST_RDAT      = 4'd7,
        ST_RDAT_ACK  = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    // SDA level seen on the ninth clock of a byte
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Which half of the 16-bit word the current data byte carries
    localparam logic PHASE_MSB = 1'b0;
    localparam logic PHASE_LSB = 1'b1;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h48;

endpackage

// File: rtl/sensor_i2c_slave_in_filter.sv
// ---------------------------------------------------------------------------
// i2c_in_filter
//   Conditions one open-drain pad level: 2-flop synchronizer, then a
//   stability filter that only accepts a new level after FILTER_LEN
//   consecutive identical samples, then edge detection on the filtered level.
//   Everything resets to level 1 (idle bus).
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   raw pad level
//   level  out  filtered level
//   rise   out  filtered level went 0->1 (valid the cycle after the change)
//   fall   out  filtered level went 1->0 (valid the cycle after the change)
// ---------------------------------------------------------------------------
module i2c_in_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= 4'd0;
            level   <= 1'b1;
            level_d <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], din};
            level_d <= level;
            // cnt_q counts how many samples in a row disagreed with level;
            // any agreeing sample restarts the run, so short glitches vanish.
            if (sync_q[1] == level) begin
                cnt_q <= 4'd0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                level <= sync_q[1];
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/sensor_i2c_slave.sv
// ---------------------------------------------------------------------------
// sensor_i2c_slave
//   I2C responder emulating a sensor register port. 7-bit device address,
//   8-bit register address, 16-bit data words sent MSB byte first, register
//   address auto-increments after every word. Register storage is external.
//
//   Register-file strobes: reg_we and reg_re are single-cycle pulses with no
//   back-pressure. reg_wdata/reg_addr are valid in the reg_we cycle; for a
//   read, reg_addr is valid in the reg_re cycle and reg_rdata is sampled two
//   cycles after reg_re rose.
//
// Ports
//   mclk        in   system clock
//   mrst        in   asynchronous active-low reset
//   scl_in      in   SCL pad level
//   sda_in      in   SDA pad level
//   sda_out     out  constant 0 (open-drain data)
//   sda_en      out  1 = pull SDA low
//   reg_addr    out  current register address
//   reg_wdata   out  write data, valid with reg_we
//   reg_we      out  one-cycle write strobe
//   reg_re      out  one-cycle read-fetch strobe
//   reg_rdata   in   read data
//   busy        out  START accepted and no STOP/reset since
//   addressed   out  current transaction matched SLAVE_ADDR
//   debug_state out  FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module sensor_i2c_slave
    import sensor_i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         FILTER_LEN = 3,
    parameter int         SDA_HOLD   = 2
) (
    input  logic        mclk,
    input  logic        mrst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        sda_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        addressed,
    output logic [3:0]  debug_state
);

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (mclk),
        .rst_n (mrst),
        .din   (scl_in),
        .level (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (mclk),
        .rst_n (mrst),
        .din   (sda_in),
        .level (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_cond;
    logic stop_cond;

    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t      state_q, state_next;
    logic [2:0]  bit_cnt;
    logic [15:0] shreg;
    logic [7:0]  msb_q;
    logic        phase_q;
    logic        rw_q;
    logic        re_d1;
    logic [3:0]  hold_cnt;

    logic [7:0]  rx_byte;
    logic        last_bit;

    // Byte as it stands once the bit on this rising edge is shifted in
    assign rx_byte  = {shreg[6:0], sda_f};
    assign last_bit = (bit_cnt == 3'd7);

    // FSM control strobes
    logic shift_rx, shift_tx;
    logic addr_load, addr_inc;
    logic we_set, re_set;
    logic msb_store, match_set;
    logic phase_clr, phase_tog;
    logic drive_target;

    always_ff @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // START/STOP outrank any bit event seen in the same cycle.
    always_comb begin
        state_next = state_q;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        addr_load  = 1'b0;
        addr_inc   = 1'b0;
        we_set     = 1'b0;
        re_set     = 1'b0;
        msb_store  = 1'b0;
        match_set  = 1'b0;
        phase_clr  = 1'b0;
        phase_tog  = 1'b0;

        if (start_cond) begin
            state_next = ST_DEVA;
        end else if (stop_cond) begin
            state_next = ST_IDLE;
        end else if (scl_rise) begin
            case (state_q)
                ST_DEVA: begin
                    shift_rx = 1'b1;
                    if (last_bit) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            state_next = ST_DEVA_ACK;
                            match_set  = 1'b1;
                            phase_clr  = 1'b1;
                            re_set     = rx_byte[0];
                        end else begin
                            state_next = ST_WAIT_STOP;
                        end
                    end
                end
                ST_DEVA_ACK: begin
                    state_next = rw_q ? ST_RDAT : ST_REGA;
                end
                ST_REGA: begin
                    shift_rx = 1'b1;
                    if (last_bit) begin
                        addr_load  = 1'b1;
                        state_next = ST_REGA_ACK;
                    end
                end
                ST_REGA_ACK: begin
                    state_next = ST_WDAT;
                    phase_clr  = 1'b1;
                end
                ST_WDAT: begin
                    shift_rx = 1'b1;
                    if (last_bit) begin
                        state_next = ST_WDAT_ACK;
                        if (phase_q == PHASE_MSB) begin
                            msb_store = 1'b1;
                        end else begin
                            we_set = 1'b1;
                        end
                    end
                end
                ST_WDAT_ACK: begin
                    state_next = ST_WDAT;
                    phase_tog  = 1'b1;
                end
                ST_RDAT: begin
                    shift_tx = 1'b1;
                    if (last_bit) begin
                        state_next = ST_RDAT_ACK;
                    end
                end
                ST_RDAT_ACK: begin
                    if (sda_f == ACK) begin
                        state_next = ST_RDAT;
                        phase_tog  = 1'b1;
                        // Word fully sent: advance and fetch the next one
                        if (phase_q == PHASE_LSB) begin
                            addr_inc = 1'b1;
                            re_set   = 1'b1;
                        end
                    end else begin
                        state_next = ST_WAIT_STOP;
                    end
                end
                default: begin
                    state_next = state_q;
                end
            endcase
        end
    end

    // Level SDA should take once the post-falling-edge hold expires. It is
    // evaluated against the state entered on the preceding rising edge.
    always_comb begin
        drive_target = 1'b0;
        case (state_q)
            ST_DEVA_ACK, ST_REGA_ACK, ST_WDAT_ACK: drive_target = 1'b1;
            ST_RDAT:                               drive_target = ~shreg[15];
            default:                               drive_target = 1'b0;
        endcase
    end

    always_ff @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            bit_cnt   <= 3'd0;
            shreg     <= 16'd0;
            msb_q     <= 8'd0;
            phase_q   <= PHASE_MSB;
            rw_q      <= 1'b0;
            re_d1     <= 1'b0;
            hold_cnt  <= 4'd0;
            sda_en    <= 1'b0;
            reg_addr  <= 8'd0;
            reg_wdata <= 16'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            addressed <= 1'b0;
        end else begin
            reg_we <= we_set;
            reg_re <= re_set;
            re_d1  <= reg_re;

            if (start_cond) begin
                bit_cnt <= 3'd0;
            end else if (shift_rx || shift_tx) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Read data lands two cycles after reg_re, well inside SCL high
            if (re_d1) begin
                shreg <= reg_rdata;
            end else if (shift_rx) begin
                shreg[7:0] <= rx_byte;
            end else if (shift_tx) begin
                shreg <= {shreg[14:0], 1'b0};
            end

            if (msb_store) begin
                msb_q <= rx_byte;
            end
            if (we_set) begin
                reg_wdata <= {msb_q, rx_byte};
            end

            // reg_we is already high here, so this bumps the address on the
            // cycle after the strobe.
            if (addr_load) begin
                reg_addr <= rx_byte;
            end else if (addr_inc || reg_we) begin
                reg_addr <= reg_addr + 8'd1;
            end

            if (match_set) begin
                rw_q <= rx_byte[0];
            end

            if (phase_clr) begin
                phase_q <= PHASE_MSB;
            end else if (phase_tog) begin
                phase_q <= ~phase_q;
            end

            if (start_cond || stop_cond) begin
                addressed <= 1'b0;
            end else if (match_set) begin
                addressed <= 1'b1;
            end

            // SDA only changes SDA_HOLD cycles after SCL falls, except that
            // START/STOP release it immediately.
            if (start_cond || stop_cond) begin
                hold_cnt <= 4'd0;
                sda_en   <= 1'b0;
            end else if (scl_fall) begin
                hold_cnt <= 4'(SDA_HOLD);
            end else if (hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
                if (hold_cnt == 4'd1) begin
                    sda_en <= drive_target;
                end
            end
        end
    end

    assign sda_out     = 1'b0;
    assign busy        = (state_q != ST_IDLE);
    assign debug_state = state_q;

endmodule

// File: tb/tb_sensor_i2c_slave.sv
`timescale 1ns/1ps
module tb_sensor_i2c_slave;

  localparam int HALF = 20;   // mclk cycles per SCL phase

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  logic mrst = 1'b0;
  logic scl_in = 1'b1;
  logic sda_m = 1'b1;         // master's open-drain drive (1 = released)

  logic        sda_in, sda_out, sda_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy, addressed;
  logic [3:0]  debug_state;

  always #5 mclk = ~mclk;

  // wired-AND bus
  assign sda_in = sda_m & ~sda_en;
  // external register file model: value = addr * 0x0101
  assign reg_rdata = {reg_addr, reg_addr};

  sensor_i2c_slave dut (
    .mclk        (mclk),
    .mrst        (mrst),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda_out     (sda_out),
    .sda_en      (sda_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy),
    .addressed   (addressed),
    .debug_state (debug_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [23:0] exp_q[$];
  logic [23:0] we_log [0:63];
  int we_n = 0;
  int we_rd = 0;
  int re_n = 0;
  int en_n = 0;

  always @(negedge mclk) begin
    if (reg_we && we_n < 64) begin
      we_log[we_n] <= {reg_addr, reg_wdata};
      we_n <= we_n + 1;
    end
    if (reg_re) re_n <= re_n + 1;
    if (sda_en) en_n <= en_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_writes();
    logic [23:0] e;
    check("we_count", 32'(we_n - we_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (we_rd < we_n) begin
        check("we_addr_data", {8'd0, we_log[we_rd]}, {8'd0, e});
        we_rd = we_rd + 1;
      end
    end
    we_rd = we_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic i2c_start();
    wait_cyc(HALF/2); sda_m = 1'b1;
    wait_cyc(HALF/2); scl_in = 1'b1;
    wait_cyc(HALF/2); sda_m = 1'b0;
    wait_cyc(HALF/2); scl_in = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(HALF/2); sda_m = 1'b0;
    wait_cyc(HALF/2); scl_in = 1'b1;
    wait_cyc(HALF/2); sda_m = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    wait_cyc(HALF/2); sda_m = b;
    wait_cyc(HALF/2); scl_in = 1'b1;
    wait_cyc(HALF/2);
    if (glitch) begin
      sda_m = 1'b0;
      wait_cyc(1);
      sda_m = b;
    end
    wait_cyc(HALF/2); scl_in = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(HALF/2); sda_m = 1'b1;
    wait_cyc(HALF/2); scl_in = 1'b1;
    wait_cyc(HALF/2); b = sda_in;
    wait_cyc(HALF/2); scl_in = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]        dev;
    logic [7:0]        ra;
    logic [1:0][15:0]  wd;
    int                nw;
    logic              exp_ack;
    logic [7:0]        exp_addr;
  } wvec_t;

  wvec_t vecs [5];

  initial begin
    logic ack;
    logic [7:0] d;
    int en0, re0;

    vecs[0] = '{dev: 8'h90, ra: 8'h05, wd: {16'hABCD, 16'h1234}, nw: 2, exp_ack: 1'b0, exp_addr: 8'h07};
    vecs[1] = '{dev: 8'h90, ra: 8'hFF, wd: {16'hF0F0, 16'h0F0F}, nw: 2, exp_ack: 1'b0, exp_addr: 8'h01};
    vecs[2] = '{dev: 8'h90, ra: 8'h40, wd: {16'h0000, 16'h8001}, nw: 1, exp_ack: 1'b0, exp_addr: 8'h41};
    vecs[3] = '{dev: 8'hA0, ra: 8'h22, wd: {16'h0000, 16'h5555}, nw: 1, exp_ack: 1'b1, exp_addr: 8'h41};
    vecs[4] = '{dev: 8'h92, ra: 8'h33, wd: {16'h0000, 16'h6666}, nw: 1, exp_ack: 1'b1, exp_addr: 8'h41};

    // reset state
    wait_cyc(5);
    check("rst_sda_en", {31'd0, sda_en}, 32'd0);
    check("rst_reg_we", {31'd0, reg_we}, 32'd0);
    check("rst_reg_re", {31'd0, reg_re}, 32'd0);
    check("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addressed", {31'd0, addressed}, 32'd0);
    check("rst_state", {28'd0, debug_state}, 32'd0);
    mrst = 1'b1;
    wait_cyc(HALF);

    // table-driven write transactions
    for (int v = 0; v < 5; v++) begin
      en0 = en_n;
      re0 = re_n;
      i2c_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      write_byte(vecs[v].dev, -1, ack);
      check("dev_ack", {31'd0, ack}, {31'd0, vecs[v].exp_ack});
      check("addressed_mid", {31'd0, addressed}, {31'd0, ~vecs[v].exp_ack});
      write_byte(vecs[v].ra, -1, ack);
      check("rega_ack", {31'd0, ack}, {31'd0, vecs[v].exp_ack});
      for (int w = 0; w < vecs[v].nw; w++) begin
        write_byte(vecs[v].wd[w][15:8], -1, ack);
        check("wmsb_ack", {31'd0, ack}, {31'd0, vecs[v].exp_ack});
        write_byte(vecs[v].wd[w][7:0], -1, ack);
        check("wlsb_ack", {31'd0, ack}, {31'd0, vecs[v].exp_ack});
        if (!vecs[v].exp_ack) exp_q.push_back({vecs[v].ra + 8'(w), vecs[v].wd[w]});
      end
      i2c_stop();
      check("busy_after_stop", {31'd0, busy}, 32'd0);
      check("addressed_after_stop", {31'd0, addressed}, 32'd0);
      check("reg_addr_final", {24'd0, reg_addr}, {24'd0, vecs[v].exp_addr});
      check("re_count_wr", 32'(re_n - re0), 32'd0);
      check_writes();
      if (vecs[v].exp_ack) check("sda_en_silent", 32'(en_n - en0), 32'd0);
    end

    // write register pointer, repeated START, 4-byte read
    re0 = re_n;
    i2c_start();
    write_byte(8'h90, -1, ack); check("rd_dev_w_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h10, -1, ack); check("rd_rega_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    check("rd_busy_rs", {31'd0, busy}, 32'd1);
    write_byte(8'h91, -1, ack); check("rd_dev_r_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b0, d); check("rd_byte0", {24'd0, d}, 32'h10);
    read_byte(1'b0, d); check("rd_byte1", {24'd0, d}, 32'h10);
    read_byte(1'b0, d); check("rd_byte2", {24'd0, d}, 32'h11);
    read_byte(1'b1, d); check("rd_byte3", {24'd0, d}, 32'h11);
    check("rd_re_count", 32'(re_n - re0), 32'd2);
    check("rd_busy_before_stop", {31'd0, busy}, 32'd1);
    i2c_stop();
    check("rd_busy_after_stop", {31'd0, busy}, 32'd0);
    check("rd_reg_addr", {24'd0, reg_addr}, 32'h11);
    check_writes();

    // STOP after only the MSB byte of a word
    i2c_start();
    write_byte(8'h90, -1, ack); check("mw_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h20, -1, ack); check("mw_rega_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h55, -1, ack); check("mw_msb_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check("mw_reg_addr", {24'd0, reg_addr}, 32'h20);
    check("mw_busy", {31'd0, busy}, 32'd0);
    check_writes();

    // 1-cycle SDA glitch during SCL high on a '1' bit
    i2c_start();
    write_byte(8'h90, -1, ack); check("gl_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h30, -1, ack); check("gl_rega_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h12, 4, ack);  check("gl_msb_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h34, 2, ack);  check("gl_lsb_ack", {31'd0, ack}, 32'd0);
    check("gl_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({8'h30, 16'h1234});
    i2c_stop();
    check("gl_reg_addr", {24'd0, reg_addr}, 32'h31);
    check_writes();

    // reset asserted while the slave drives an ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(8'h90 >> i, 1'b0);
    wait_cyc(HALF/2); sda_m = 1'b1;
    wait_cyc(HALF/2); scl_in = 1'b1;
    wait_cyc(HALF/2);
    check("rst_ack_driven", {31'd0, sda_en}, 32'd1);
    mrst = 1'b0;
    #1;
    check("rst_mid_sda_en", {31'd0, sda_en}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_addressed", {31'd0, addressed}, 32'd0);
    check("rst_mid_reg_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_mid_reg_wdata", {16'd0, reg_wdata}, 32'd0);
    wait_cyc(5);
    mrst = 1'b1;
    wait_cyc(HALF);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    i2c_start();
    write_byte(8'h90, -1, ack); check("pr_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h00, -1, ack); check("pr_rega_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hFF, -1, ack); check("pr_msb_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hFF, -1, ack); check("pr_lsb_ack", {31'd0, ack}, 32'd0);
    exp_q.push_back({8'h00, 16'hFFFF});
    i2c_stop();
    check("pr_reg_addr", {24'd0, reg_addr}, 32'h01);
    check_writes();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
